uart_tx_flowctl: RTL and testbench

UART_TX_FLOWCTL -- requirements
Module: uart_tx_flowctl

---
 rtl/uart_tx_flowctl.sv | 134 +++++++++++++
 tb/tb_uart_tx_flowctl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_flowctl.sv
// uart_tx_flowctl: UART transmitter with a small word FIFO and CTS gating at frame start.
module uart_tx_flowctl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int DIV_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DIV_W-1:0]         baud_div,
   input  logic [1:0]               parity_mode,
   input  logic                     two_stop,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   input  logic                     cts,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state, nstate;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [DIV_W-1:0]  cnt, ncnt, div_l, div_m1;
   logic [DATA_W-1:0] sh, nsh;
   logic [2:0]        idx, nidx;
   logic [1:0]        pm_l;
   logic              two_l, par, ntx, push, pop, end_bit, start_ok, par_on;

   assign in_ready = !rst && level < LW'(DEPTH);
   assign push     = in_valid && in_ready;
   assign busy     = state != IDLE;
   assign div_m1   = div_l < DIV_W'(2) ? DIV_W'(1) : div_l - 1'b1;
   assign end_bit  = cnt == div_m1;
   assign start_ok = level != '0 && cts;
   assign par_on   = pm_l == 2'b01 || pm_l == 2'b10;

   // tx is produced from the next state so the line changes on the same edge as the FSM
   always_comb begin
      nstate = state;
      ncnt   = cnt + 1'b1;
      nidx   = idx;
      nsh    = sh;
      ntx    = tx;
      pop    = 1'b0;
      case (state)
         IDLE: begin
            ncnt = '0;
            ntx  = 1'b1;
            if (start_ok) begin
               pop    = 1'b1;
               nstate = START;
               ntx    = 1'b0;
            end
         end
         START: if (end_bit) begin
            nstate = DATA;
            ncnt   = '0;
            nidx   = '0;
            ntx    = sh[0];
            nsh    = sh >> 1;
         end
         DATA: if (end_bit) begin
            ncnt = '0;
            if (idx == 3'(DATA_W - 1)) begin
               nstate = par_on ? PARITY : STOP;
               ntx    = par_on ? par : 1'b1;
               nidx   = '0;
            end else begin
               nidx = idx + 1'b1;
               ntx  = sh[0];
               nsh  = sh >> 1;
            end
         end
         PARITY: if (end_bit) begin
            nstate = STOP;
            ncnt   = '0;
            nidx   = '0;
            ntx    = 1'b1;
         end
         STOP: if (end_bit) begin
            ncnt = '0;
            if (idx == {2'b00, two_l}) begin
               pop    = start_ok;
               nstate = start_ok ? START : IDLE;
               ntx    = !start_ok;
            end else begin
               nidx = idx + 1'b1;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tx    <= 1'b1;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         wp    <= '0;
         rp    <= '0;
         level <= '0;
         div_l <= '0;
         pm_l  <= '0;
         two_l <= 1'b0;
         par   <= 1'b0;
      end else begin
         state <= nstate;
         tx    <= ntx;
         cnt   <= ncnt;
         idx   <= nidx;
         sh    <= pop ? mem[rp] : nsh;
         level <= level + LW'(push) - LW'(pop);
         if (push) wp <= wp + 1'b1;
         if (pop) begin
            rp    <= rp + 1'b1;
            div_l <= baud_div;
            pm_l  <= parity_mode;
            two_l <= two_stop;
            par   <= ^mem[rp] ^ (parity_mode == 2'b01);
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_flowctl.sv
// tb_uart_tx_flowctl: checks the serial waveform against bit lists built from the frame format.
module tb_uart_tx_flowctl;
   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int DIVW = 16;

   logic            clk = 1'b0, rst = 1'b1;
   logic [DIVW-1:0] baud_div = 16'd4;
   logic [1:0]      parity_mode = 2'b00;
   logic            two_stop = 1'b0, in_valid = 1'b0, cts = 1'b1;
   logic [DW-1:0]   in_data = '0;
   logic            in_ready, tx, busy;
   logic [2:0]      level;
   int              compared = 0, mismatched = 0;
   bit              exp_bits[$];

   always #5 clk = ~clk;

   uart_tx_flowctl #(.DATA_W(DW), .DEPTH(DEPTH), .DIV_W(DIVW)) dut (
      .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
      .two_stop(two_stop), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .cts(cts), .tx(tx), .busy(busy), .level(level)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic add_frame(input logic [DW-1:0] d, input logic [1:0] pm, input logic t);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
      if (pm == 2'b01) exp_bits.push_back(~^d);
      if (pm == 2'b10) exp_bits.push_back(^d);
      exp_bits.push_back(1'b1);
      if (t) exp_bits.push_back(1'b1);
   endtask

   task automatic push(input logic [DW-1:0] d);
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called just before the pop edge; samples every cycle of the expected line activity
   task automatic check_stream(input int div, input int nframes, input int lvl0,
                               input bit scramble, input int drop_at);
      int total = exp_bits.size() * div;
      int flen = total / nframes;
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         if (scramble && k == 0) begin
            baud_div    = 16'($urandom);
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
         end
         if (k == drop_at) cts = 1'b0;
         chk("tx", tx, exp_bits[k / div]);
         chk("busy", busy, 1);
         if (k % flen == 0) chk("level_at_start", level, lvl0 - k / flen);
      end
      exp_bits.delete();
   endtask

   task automatic idle_check();
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_tx", tx, 1);
   endtask

   initial begin
      logic [DW-1:0] w[4];
      logic [DW-1:0] d;
      int div, deff;
      logic [1:0] pm;
      logic t;

      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", in_ready, 1);

      baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
      add_frame(8'hA5, 2'b00, 1'b0);
      push(8'hA5);
      check_stream(4, 1, 0, 1'b0, -1);
      idle_check();

      baud_div = 16'd4; parity_mode = 2'b10; two_stop = 1'b0;
      add_frame(8'h07, 2'b10, 1'b0);
      push(8'h07);
      check_stream(4, 1, 0, 1'b0, -1);
      idle_check();

      baud_div = 16'd4; parity_mode = 2'b01; two_stop = 1'b0;
      add_frame(8'h07, 2'b01, 1'b0);
      push(8'h07);
      check_stream(4, 1, 0, 1'b0, -1);
      idle_check();

      baud_div = 16'd1; parity_mode = 2'b00; two_stop = 1'b0;
      add_frame(8'h3C, 2'b00, 1'b0);
      push(8'h3C);
      check_stream(2, 1, 0, 1'b0, -1);
      idle_check();

      for (int n = 0; n < 10; n++) begin
         d    = 8'($urandom);
         div  = $urandom_range(0, 5);
         deff = div < 2 ? 2 : div;
         pm   = 2'($urandom_range(0, 3));
         t    = 1'($urandom_range(0, 1));
         baud_div = 16'(div); parity_mode = pm; two_stop = t;
         add_frame(d, pm, t);
         push(d);
         check_stream(deff, 1, 0, 1'b1, -1);
         idle_check();
      end

      baud_div = 16'd2; parity_mode = 2'b00; two_stop = 1'b0; cts = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w[i] = 8'($urandom);
         add_frame(w[i], 2'b00, 1'b0);
         push(w[i]);
      end
      chk("full_level", level, 4);
      chk("full_in_ready", in_ready, 0);
      chk("cts_low_tx", tx, 1);
      push(8'hFF);
      chk("drop_fifth_level", level, 4);
      cts = 1'b1;
      check_stream(2, 4, 3, 1'b0, -1);
      idle_check();

      baud_div = 16'd3; parity_mode = 2'b10; two_stop = 1'b1; cts = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w[i] = 8'($urandom);
         push(w[i]);
      end
      add_frame(w[0], 2'b10, 1'b1);
      cts = 1'b1;
      check_stream(3, 1, 2, 1'b0, 10);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("cts_hold_tx", tx, 1);
      end
      chk("cts_hold_level", level, 2);
      chk("cts_hold_busy", busy, 0);
      add_frame(w[1], 2'b10, 1'b1);
      add_frame(w[2], 2'b10, 1'b1);
      cts = 1'b1;
      check_stream(3, 2, 1, 1'b0, -1);
      idle_check();

      baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0; cts = 1'b0;
      for (int i = 0; i < 4; i++) push(8'($urandom));
      cts = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_frame_busy", busy, 1);
      chk("mid_frame_level", level, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", tx, 1);
      chk("abort_level", level, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      rst = 1'b0;
      #1 chk("abort_release_in_ready", in_ready, 1);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         chk("after_abort_tx", tx, 1);
         chk("after_abort_busy", busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
